// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: fetch/dispatch packet type and default buffer depth
package inst_buffer_pkg;
  localparam int IB_DEPTH = 8;
  typedef struct packed {
    logic        valid;
    logic        predict_direction;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } IF_ID_PACKET;
endpackage

// File: rtl/ib_lead_count.sv
// ib_lead_count: length of the leading valid run from slot 2 down, ending at the first stop slot (inclusive)
//   valid[2:0] : per-slot valid, slot 2 oldest
//   stop[2:0]  : per-slot stop flag (predicted taken)
//   n[1:0]     : number of slots in the run, 0..3
module ib_lead_count (
  input  logic [2:0] valid,
  input  logic [2:0] stop,
  output logic [1:0] n
);
  assign n = !valid[2] ? 2'd0 :
             (stop[2] || !valid[1]) ? 2'd1 :
             (stop[1] || !valid[0]) ? 2'd2 : 2'd3;
endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction buffer between fetch and dispatch
//   clock, reset (async, active-low), squash (flush)
//   if_packet_in[2:0]   : fetch group, slot 2 oldest
//   d_stall[2:0]        : per-slot dispatch stall
//   dis_packet_out[2:0] : 3 oldest entries, slot 2 = head
//   ib_ready            : at least 3 free entries (registered count)
//   ib_count, ib_empty  : occupancy
//   IB_BYPASS_EN        : when defined, an empty buffer forwards the fetch group combinationally
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  IF_ID_PACKET [2:0]            if_packet_in,
  input  logic [2:0]                   d_stall,
  output IF_ID_PACKET [2:0]            dis_packet_out,
  output logic                         ib_ready,
  output logic [$clog2(DEPTH+1)-1:0]   ib_count,
  output logic                         ib_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  IF_ID_PACKET mem [DEPTH];
  IF_ID_PACKET [2:0] stored, wdata;
  logic [PW-1:0] head, tail;
  logic [2:0] enq_v, enq_s, deq_v, deq_s, we, sum;
  logic [1:0] enq_n, deq_n, off;
  logic bypass;
  assign ib_ready = ib_count <= CW'(DEPTH - 3);
  assign ib_empty = ib_count == '0;
  assign enq_v = ib_ready ? {if_packet_in[2].valid, if_packet_in[1].valid, if_packet_in[0].valid} : 3'b000;
  assign enq_s = {if_packet_in[2].predict_direction, if_packet_in[1].predict_direction, if_packet_in[0].predict_direction};
  ib_lead_count u_enq (.valid(enq_v), .stop(enq_s), .n(enq_n));
  always_comb begin
    for (int k = 0; k < 3; k++)
      stored[2-k] = ib_count > CW'(k) ? mem[head + PW'(k)] : '0;
`ifdef IB_BYPASS_EN
    bypass = ib_empty && ib_ready && !squash;
    for (int k = 0; k < 3; k++)
      dis_packet_out[2-k] = bypass ? (enq_n > 2'(k) ? if_packet_in[2-k] : '0) : stored[2-k];
`else
    bypass = 1'b0;
    dis_packet_out = stored;
`endif
  end
  assign deq_v = {dis_packet_out[2].valid && !d_stall[2], dis_packet_out[1].valid && !d_stall[1], dis_packet_out[0].valid && !d_stall[0]};
  assign deq_s = {dis_packet_out[2].predict_direction, dis_packet_out[1].predict_direction, dis_packet_out[0].predict_direction};
  ib_lead_count u_deq (.valid(deq_v), .stop(deq_s), .n(deq_n));
  // Bypassed slots already taken by dispatch are skipped when writing
  assign off = bypass ? deq_n : 2'd0;
  always_comb begin
    we = '0;
    wdata = '0;
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      sum = 3'(i) + {1'b0, off};
      we[i] = !squash && sum < {1'b0, enq_n};
      wdata[i] = we[i] ? if_packet_in[2'(3'd2 - sum)] : '0;
    end
  end
  always_ff @(posedge clock)
    for (int i = 0; i < 3; i++)
      if (we[i]) mem[tail + PW'(i)] <= wdata[i];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      ib_count <= '0;
    end else if (squash) begin
      head <= '0;
      tail <= '0;
      ib_count <= '0;
    end else begin
      head <= head + PW'(deq_n - off);
      tail <= tail + PW'(enq_n - off);
      ib_count <= ib_count + CW'(enq_n) - CW'(deq_n);
    end
endmodule
